score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter COMBO_STEP, default 3, consecutive hits needed to raise base_score by 1.
REQ-002 Parameter BASE_MAX, default 10, ceiling for base_score.
REQ-003 Parameter SCORE_MAX, default 999, saturation ceiling for score.
REQ-004 clk_1mhz  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse, begins a new game from IDLE or OVER, or restarts during PLAY.
REQ-007 game_over  input  1  one-cycle pulse from the game timer or lives logic, ends PLAY.
REQ-008 hit  input  1  one-cycle pulse, mole struck.
REQ-009 miss  input  1  one-cycle pulse, mole escaped or wrong button pressed.
REQ-010 score  output  10  accumulated score, 0..SCORE_MAX, drives the 7-segment array driver.
REQ-011 base_score  output  7  points awarded per hit, 0..BASE_MAX, drives the 7-segment array driver.
REQ-012 high_score  output  10  best final score since reset.
REQ-013 playing  output  1  high while in state PLAY.
REQ-014 score_upd  output  1  one-cycle strobe, high in the cycle score or base_score changes due to a hit or miss.
REQ-015 saturated  output  1  sticky flag, set when a hit is clipped at SCORE_MAX, cleared on start.

Function
REQ-016 The FSM SHALL have three states: IDLE, PLAY and OVER.
REQ-017 IDLE -> PLAY on start; OVER -> PLAY on start; PLAY -> PLAY (restart) on start; PLAY -> OVER on game_over.
REQ-018 On every start: score=0, base_score=1, combo count=0, saturated=0, effective next cycle.
REQ-019 In IDLE and OVER, hit, miss and game_over SHALL be ignored; score and base_score SHALL hold.
REQ-020 In PLAY, a hit SHALL set score <= min(score + base_score, SCORE_MAX), visible one cycle after the hit pulse; the base_score used is the value before that hit.
REQ-021 A hit SHALL increment the combo count; when the count reaches COMBO_STEP it SHALL clear to 0 and base_score SHALL increment in the same cycle as the score update, capped at BASE_MAX (the count still clears at the cap).
REQ-022 In PLAY, a miss SHALL set base_score=1 and combo count=0, and SHALL leave score unchanged.
REQ-023 hit and miss in the same cycle SHALL be treated as a miss only.
REQ-024 start in the same cycle as hit, miss or game_over SHALL take priority; the other inputs are discarded.
REQ-025 game_over in the same cycle as hit or miss SHALL apply the hit or miss first, then enter OVER with the updated score.
REQ-026 On entering OVER, high_score SHALL load the final score if it exceeds high_score; high_score SHALL NOT change on start.
REQ-027 Addition SHALL use an 11-bit intermediate before clipping, so no wrap-around occurs.
REQ-028 saturated SHALL set when score + base_score > SCORE_MAX on a hit.
REQ-029 score_upd SHALL pulse for one cycle after each accepted hit or miss, aligned with the new output values; it SHALL NOT pulse on start.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While rst is high: state=IDLE, score=0, base_score=0, high_score=0, combo count=0, playing=0, score_upd=0, saturated=0.
REQ-032 rst asserted mid-PLAY SHALL abort immediately to the reset values; no high_score update occurs.

Verification
REQ-033 Reset, then start, then 3 hits -> score 1, 2, 3; base_score becomes 2 with the third update; score_upd pulses 3 times.
REQ-034 Continue with 3 more hits, then a miss -> score 5, 7, 9; base_score 3, then 1 after the miss; score unchanged at 9.
REQ-035 COMBO_STEP=1, 15 hits -> base_score climbs 1..10 and holds at 10; score = 1+2+...+10 + 5*10 = 105.
REQ-036 Preload score near 999 via a hit stream, then a hit with base 10 at score 995 -> score 999, saturated=1; start -> saturated=0, score=0.
REQ-037 Same-cycle hit+miss -> treated as a miss; same-cycle game_over+hit -> score includes the hit, state OVER, high_score updated.
REQ-038 hit or miss in IDLE or OVER -> no change and no score_upd; rst mid-game -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/score_keeper_if.sv
// Game-control inputs and display/status outputs of the whack-a-mole score keeper.
// The master side drives the control pulses; the slave side is the score keeper.
interface score_keeper_if;
    logic       start;
    logic       game_over;
    logic       hit;
    logic       miss;
    logic [9:0] score;
    logic [6:0] base_score;
    logic [9:0] high_score;
    logic       playing;
    logic       score_upd;
    logic       saturated;

    modport master (
        output start, game_over, hit, miss,
        input  score, base_score, high_score, playing, score_upd, saturated
    );

    modport slave (
        input  start, game_over, hit, miss,
        output score, base_score, high_score, playing, score_upd, saturated
    );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: a hit adds base_score to score, and every COMBO_STEP consecutive hits
// raise base_score. All outputs are registered.
module score_keeper #(
    parameter int COMBO_STEP = 3,
    parameter int BASE_MAX   = 10,
    parameter int SCORE_MAX  = 999
) (
    input  logic          clk_1mhz,
    input  logic          rst,
    score_keeper_if.slave bus
);
    localparam int CW = (COMBO_STEP < 2) ? 1 : $clog2(COMBO_STEP + 1);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t        state_q, state_d;
    logic [9:0]    score_q, score_d;
    logic [6:0]    base_q, base_d;
    logic [9:0]    high_q, high_d;
    logic [CW-1:0] combo_q, combo_d;
    logic          playing_q, playing_d;
    logic          upd_q, upd_d;
    logic          sat_q, sat_d;

    logic [10:0]   sum;
    logic [CW-1:0] combo_inc;

    // Widened to 11 bits so the score plus base_score sum cannot wrap before it is clipped.
    assign sum       = {1'b0, score_q} + {4'd0, base_q};
    assign combo_inc = combo_q + CW'(1);

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        score_d = score_q;
        base_d  = base_q;
        high_d  = high_q;
        combo_d = combo_q;
        upd_d   = 1'b0;
        sat_d   = sat_q;

        if (bus.start) begin
            state_d = PLAY;
            score_d = '0;
            base_d  = 7'd1;
            combo_d = '0;
            sat_d   = 1'b0;
        end else if (state_q == PLAY) begin
            if (bus.miss) begin
                base_d  = 7'd1;
                combo_d = '0;
                upd_d   = 1'b1;
            end else if (bus.hit) begin
                upd_d = 1'b1;
                if (sum > 11'(SCORE_MAX)) begin
                    score_d = 10'(SCORE_MAX);
                    sat_d   = 1'b1;
                end else begin
                    score_d = sum[9:0];
                end
                // The combo count clears even when base_score is already at its cap.
                if (combo_inc == CW'(COMBO_STEP)) begin
                    combo_d = '0;
                    if (base_q < 7'(BASE_MAX)) base_d = base_q + 7'd1;
                end else begin
                    combo_d = combo_inc;
                end
            end

            // A hit or miss in the same cycle is already folded into score_d here.
            if (bus.game_over) begin
                state_d = OVER;
                if (score_d > high_q) high_d = score_d;
            end
        end

        playing_d = (state_d == PLAY);
    end

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            score_q   <= '0;
            base_q    <= '0;
            high_q    <= '0;
            combo_q   <= '0;
            playing_q <= 1'b0;
            upd_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the values from before this edge.
            state_q   <= state_d;
            score_q   <= score_d;
            base_q    <= base_d;
            high_q    <= high_d;
            combo_q   <= combo_d;
            playing_q <= playing_d;
            upd_q     <= upd_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.base_score = base_q;
    assign bus.high_score = high_q;
    assign bus.playing    = playing_q;
    assign bus.score_upd  = upd_q;
    assign bus.saturated  = sat_q;
endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a directed vector table on the default configuration, plus
// hand-written sequences for combo saturation (COMBO_STEP=1), score clipping and async reset.
module tb_score_keeper;
    logic clk_1mhz = 1'b0;
    logic rst      = 1'b1;

    always #5 clk_1mhz = ~clk_1mhz;

    score_keeper_if bus_a ();
    score_keeper_if bus_b ();

    score_keeper dut_a (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .bus      (bus_a.slave)
    );

    score_keeper #(.COMBO_STEP(1)) dut_b (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .bus      (bus_b.slave)
    );

    typedef struct {
        logic       start, game_over, hit, miss;
        int         score, base, upd, playing, sat, high;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add(input logic s, g, h, m, input int sc, b, u, p, sat, hi);
        vec_t v;
        v.start = s; v.game_over = g; v.hit = h; v.miss = m;
        v.score = sc; v.base = b; v.upd = u; v.playing = p; v.sat = sat; v.high = hi;
        vecs.push_back(v);
    endtask

    // Drive one cycle of pulses on the chosen instance, then sample just after the edge.
    task automatic step(input int which, input logic s, g, h, m);
        @(negedge clk_1mhz);
        if (which == 0) begin
            bus_a.start = s; bus_a.game_over = g; bus_a.hit = h; bus_a.miss = m;
        end else begin
            bus_b.start = s; bus_b.game_over = g; bus_b.hit = h; bus_b.miss = m;
        end
        @(posedge clk_1mhz);
        #1;
        bus_a.start = 0; bus_a.game_over = 0; bus_a.hit = 0; bus_a.miss = 0;
        bus_b.start = 0; bus_b.game_over = 0; bus_b.hit = 0; bus_b.miss = 0;
    endtask

    task automatic check_all_a(input string tag, input int sc, b, u, p, sat, hi);
        check({tag, " score"},      int'(bus_a.score),      sc);
        check({tag, " base_score"}, int'(bus_a.base_score), b);
        check({tag, " score_upd"},  int'(bus_a.score_upd),  u);
        check({tag, " playing"},    int'(bus_a.playing),    p);
        check({tag, " saturated"},  int'(bus_a.saturated),  sat);
        check({tag, " high_score"}, int'(bus_a.high_score), hi);
    endtask

    initial begin
        int exp_score, exp_base;

        bus_a.start = 0; bus_a.game_over = 0; bus_a.hit = 0; bus_a.miss = 0;
        bus_b.start = 0; bus_b.game_over = 0; bus_b.hit = 0; bus_b.miss = 0;

        //   st go hit miss  score base upd play sat high
        add(0, 0, 1, 0,    0, 0, 0, 0, 0,  0);  // hit ignored in IDLE
        add(0, 0, 0, 1,    0, 0, 0, 0, 0,  0);  // miss ignored in IDLE
        add(1, 0, 0, 0,    0, 1, 0, 1, 0,  0);  // start, no strobe
        add(0, 0, 1, 0,    1, 1, 1, 1, 0,  0);
        add(0, 0, 1, 0,    2, 1, 1, 1, 0,  0);
        add(0, 0, 1, 0,    3, 2, 1, 1, 0,  0);  // third hit raises base
        add(0, 0, 0, 0,    3, 2, 0, 1, 0,  0);
        add(0, 0, 1, 0,    5, 2, 1, 1, 0,  0);
        add(0, 0, 1, 0,    7, 2, 1, 1, 0,  0);
        add(0, 0, 1, 0,    9, 3, 1, 1, 0,  0);
        add(0, 0, 0, 1,    9, 1, 1, 1, 0,  0);  // miss resets base
        add(0, 0, 1, 1,    9, 1, 1, 1, 0,  0);  // hit+miss is a miss
        add(0, 0, 1, 0,   10, 1, 1, 1, 0,  0);
        add(0, 0, 1, 0,   11, 1, 1, 1, 0,  0);
        add(0, 0, 1, 1,   11, 1, 1, 1, 0,  0);  // clears the combo count of 2
        add(0, 0, 1, 0,   12, 1, 1, 1, 0,  0);
        add(0, 0, 1, 0,   13, 1, 1, 1, 0,  0);
        add(0, 1, 1, 0,   14, 2, 1, 0, 0, 14);  // game_over+hit: hit counted
        add(0, 0, 1, 0,   14, 2, 0, 0, 0, 14);  // ignored in OVER
        add(0, 0, 0, 1,   14, 2, 0, 0, 0, 14);
        add(0, 1, 0, 0,   14, 2, 0, 0, 0, 14);
        add(1, 0, 0, 0,    0, 1, 0, 1, 0, 14);  // OVER -> PLAY, high kept
        add(1, 0, 1, 0,    0, 1, 0, 1, 0, 14);  // start beats hit
        add(0, 0, 1, 0,    1, 1, 1, 1, 0, 14);
        add(0, 1, 0, 0,    1, 1, 0, 0, 0, 14);  // lower final score, high kept
        add(1, 0, 0, 0,    0, 1, 0, 1, 0, 14);
        add(0, 0, 1, 0,    1, 1, 1, 1, 0, 14);
        add(0, 0, 1, 0,    2, 1, 1, 1, 0, 14);
        add(1, 0, 0, 0,    0, 1, 0, 1, 0, 14);  // restart mid-PLAY
        add(0, 0, 1, 0,    1, 1, 1, 1, 0, 14);
        add(0, 0, 1, 0,    2, 1, 1, 1, 0, 14);
        add(0, 0, 1, 0,    3, 2, 1, 1, 0, 14);  // combo count was cleared by restart

        repeat (2) @(posedge clk_1mhz);
        #1;
        check_all_a("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk_1mhz);
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(0, vecs[i].start, vecs[i].game_over, vecs[i].hit, vecs[i].miss);
            check_all_a($sformatf("vec%0d", i), vecs[i].score, vecs[i].base,
                        vecs[i].upd, vecs[i].playing, vecs[i].sat, vecs[i].high);
        end

        // Asynchronous reset in the middle of PLAY, away from any clock edge.
        @(negedge clk_1mhz);
        #2;
        rst = 1;
        #1;
        check_all_a("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk_1mhz);
        rst = 0;

        // COMBO_STEP=1: base climbs every hit up to BASE_MAX.
        step(1, 1, 0, 0, 0);
        check("b start base", int'(bus_b.base_score), 1);
        exp_score = 0;
        exp_base  = 1;
        for (int i = 1; i <= 15; i++) begin
            step(1, 0, 0, 1, 0);
            exp_score += exp_base;
            if (exp_base < 10) exp_base++;
            check($sformatf("b hit%0d score", i), int'(bus_b.score), exp_score);
            check($sformatf("b hit%0d base", i),  int'(bus_b.base_score), exp_base);
        end
        check("b total after 15", int'(bus_b.score), 105);

        repeat (89) step(1, 0, 0, 1, 0);
        check("b preload score", int'(bus_b.score), 995);
        check("b preload sat", int'(bus_b.saturated), 0);
        step(1, 0, 0, 1, 0);
        check("b clip score", int'(bus_b.score), 999);
        check("b clip sat", int'(bus_b.saturated), 1);
        check("b clip upd", int'(bus_b.score_upd), 1);
        step(1, 0, 0, 1, 0);
        check("b hold score", int'(bus_b.score), 999);
        check("b hold sat", int'(bus_b.saturated), 1);
        step(1, 1, 0, 0, 0);
        check("b restart score", int'(bus_b.score), 0);
        check("b restart sat", int'(bus_b.saturated), 0);
        check("b restart base", int'(bus_b.base_score), 1);
        check("b restart upd", int'(bus_b.score_upd), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
